dm_access_unit: RTL and testbench

Data-memory access unit sitting in the MEM stage of the pipelined RV32I core. It consumes the load/store control that the decoder produces (MemWrite, load select, 3-bit dm_ctrl width code) together with the ALU address and rs2 data. It performs a handshaked access to a variable-latency word-wide data memory: byte-enable generation, write-data lane replication and load extraction with sign/zero extension. It stalls the pipeline for the duration of the access and flags misaligned and timed-out accesses.

---
 rtl/dm_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_dm_access_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: handshaked word-wide memory access with
// byte-lane generation, load extension, pipeline stall and error reporting.
module dm_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_ld,
  input  logic        req_st,
  input  logic [2:0]  req_dm_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] C_WORD = 3'b000;
  localparam logic [2:0] C_HS   = 3'b001;
  localparam logic [2:0] C_HU   = 3'b010;
  localparam logic [2:0] C_BS   = 3'b011;
  localparam logic [2:0] C_BU   = 3'b100;

  localparam logic [1:0] E_OK      = 2'b00;
  localparam logic [1:0] E_ILLEGAL = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ctrl_q;
  logic [1:0]       addr_lo_q;
  logic             st_q;

  logic        access, illegal, accept, finish_ok, finish_to;
  logic        is_word, is_half;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [15:0] lane16;
  logic [7:0]  lane8;
  logic [31:0] load_c;

  // Request decode: legality, byte enables and lane-replicated store data
  always_comb begin
    access  = req_valid & (req_ld | req_st);
    is_word = (req_dm_ctrl == C_WORD);
    is_half = (req_dm_ctrl == C_HS) | (req_dm_ctrl == C_HU);
    illegal = (req_dm_ctrl > C_BU)
            | (req_st & ((req_dm_ctrl == C_HU) | (req_dm_ctrl == C_BU)))
            | (is_word & (req_addr[1:0] != 2'b00))
            | (is_half & req_addr[0]);
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    case (req_dm_ctrl)
      C_WORD: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
      C_HS, C_HU: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      C_BS, C_BU: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    lane16 = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    lane8  = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    case (ctrl_q)
      C_HS:    load_c = {{16{lane16[15]}}, lane16};
      C_HU:    load_c = {16'h0, lane16};
      C_BS:    load_c = {{24{lane8[7]}}, lane8};
      C_BU:    load_c = {24'h0, lane8};
      default: load_c = mem_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = illegal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          finish_ok = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish_to = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured request, memory-side registers and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q    <= 3'b000;
      addr_lo_q <= 2'b00;
      st_q      <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= E_OK;
    end else begin
      if (accept) begin
        ctrl_q    <= req_dm_ctrl;
        addr_lo_q <= req_addr[1:0];
        st_q      <= req_st;
        if (illegal) begin
          rsp_err   <= E_ILLEGAL;
          rsp_rdata <= 32'h0;
        end else begin
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_be    <= be_c;
          mem_wdata <= wdata_c;
          mem_we    <= req_st;
        end
      end
      if (finish_ok) begin
        rsp_err   <= E_OK;
        rsp_rdata <= st_q ? 32'h0 : load_c;
        mem_we    <= 1'b0;
      end
      if (finish_to) begin
        rsp_err   <= E_TIMEOUT;
        rsp_rdata <= 32'h0;
        mem_we    <= 1'b0;
      end
    end
  end

  // Reset gates the combinational stall so an abandoned access frees the pipe at once
  assign stall     = rstn & (((state_q == S_IDLE) & access) | (state_q == S_REQ));
  assign mem_req   = (state_q == S_REQ);
  assign rsp_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, hand-written reset/idle
// sequences and randomized accesses checked against a behavioural model.
module tb_dm_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ld, req_st;
  logic [2:0]  req_dm_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  dm_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ld(req_ld), .req_st(req_st),
    .req_dm_ctrl(req_dm_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned stall;
    int unsigned lat;
    int unsigned reqs;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic        we;
    logic        stable;
    logic        done;
  } obs_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int unsigned delay;
    obs_t        exp;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  function automatic obs_t blank();
    obs_t o;
    o.stall = 0; o.lat = 0; o.reqs = 0; o.err = 2'b00; o.rdata = 32'h0;
    o.be = 4'h0; o.maddr = 32'h0; o.wdata = 32'h0; o.we = 1'b0;
    o.stable = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int unsigned dly,
                              input int unsigned e_stall, input int unsigned e_reqs,
                              input logic [1:0] e_err, input logic [31:0] e_rdata,
                              input logic [3:0] e_be, input logic [31:0] e_wd);
    vec_t v;
    v.ld = ld; v.st = st; v.ctrl = ctrl; v.addr = addr; v.wd = wd; v.rd = rd; v.delay = dly;
    v.exp = blank();
    v.exp.stall = e_stall; v.exp.lat = e_stall; v.exp.reqs = e_reqs;
    v.exp.err = e_err; v.exp.rdata = e_rdata; v.exp.be = e_be; v.exp.wdata = e_wd;
    v.exp.maddr = addr & 32'hFFFF_FFFC; v.exp.we = st;
    return v;
  endfunction

  // Reference model: response derived from access size, offset and latency
  function automatic obs_t model(input logic st, input logic [2:0] ctrl, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int unsigned dly);
    obs_t o;
    int unsigned size, off;
    longint unsigned mask, lane, acc;
    bit legal;
    o = blank();
    off = addr % 4;
    size = (ctrl == 0) ? 4 : (ctrl <= 2) ? 2 : 1;
    legal = (ctrl <= 4) && !(st && (ctrl == 2 || ctrl == 4)) && (off % size == 0);
    if (!legal) begin
      o.stall = 1; o.lat = 1; o.err = 2'b01;
      return o;
    end
    mask = (64'd1 << (8 * size)) - 1;
    acc = 0;
    for (int i = 0; i < 4 / int'(size); i++) acc += (longint'(wd) & mask) << (8 * size * i);
    o.wdata = 32'(acc);
    o.be = 4'(((1 << size) - 1) << off);
    o.maddr = addr - off;
    o.we = st;
    if (dly < TO) begin
      o.reqs = dly + 1; o.stall = dly + 2; o.lat = dly + 2;
      lane = (longint'(rd) >> (8 * off)) & mask;
      if ((ctrl == 1 || ctrl == 3) && lane > (mask >> 1)) lane = lane - (mask + 1);
      o.rdata = st ? 32'h0 : 32'(lane);
    end else begin
      o.reqs = TO; o.stall = TO + 1; o.lat = TO + 1; o.err = 2'b10;
    end
    return o;
  endfunction

  // Drives one instruction, acts as the memory, and records what the DUT did
  task automatic do_access(input logic ld, input logic st, input logic [2:0] ctrl,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int unsigned dly,
                           input logic noise, output obs_t o);
    int unsigned cyc;
    o = blank();
    o.done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_ld = ld; req_st = st; req_dm_ctrl = ctrl;
    req_addr = addr; req_wdata = wd; mem_rdata = rd;
    cyc = 0;
    while (!o.done && cyc < 40) begin
      #1;
      if (stall) o.stall++;
      if (rsp_valid) begin
        o.lat = cyc; o.err = rsp_err; o.rdata = rsp_rdata; o.done = 1'b1;
        req_valid = 1'b0; mem_ready = 1'b0;
      end else begin
        if (mem_req) begin
          if (o.reqs == 0) begin
            o.be = mem_be; o.maddr = mem_addr; o.wdata = mem_wdata; o.we = mem_we;
          end else if (o.be !== mem_be || o.maddr !== mem_addr ||
                       o.wdata !== mem_wdata || o.we !== mem_we) begin
            o.stable = 1'b0;
          end
          mem_ready = (o.reqs == dly);
          o.reqs++;
        end else begin
          mem_ready = noise & $urandom_range(0, 1);
        end
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    check({tag, ".completed"}, 32'(o.done), 32'(e.done));
    check({tag, ".stall_cycles"}, o.stall, e.stall);
    check({tag, ".rsp_latency"}, o.lat, e.lat);
    check({tag, ".req_cycles"}, o.reqs, e.reqs);
    check({tag, ".rsp_err"}, 32'(o.err), 32'(e.err));
    check({tag, ".rsp_rdata"}, o.rdata, e.rdata);
    if (e.reqs != 0 && o.reqs != 0) begin
      check({tag, ".mem_be"}, 32'(o.be), 32'(e.be));
      check({tag, ".mem_addr"}, o.maddr, e.maddr);
      check({tag, ".mem_wdata"}, o.wdata, e.wdata);
      check({tag, ".mem_we"}, 32'(o.we), 32'(e.we));
      check({tag, ".mem_stable"}, 32'(o.stable), 32'(e.stable));
    end
  endtask

  vec_t vt[16];
  obs_t o, e;

  initial begin
    rstn = 1'b0;
    req_valid = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_dm_ctrl = 3'b000;
    req_addr = 32'h100; req_wdata = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0;

    vt[0]  = mk(1, 0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h0);
    vt[1]  = mk(1, 0, 3'b011, 32'h103, 32'h0, 32'h80FF0000, 0, 2, 1, 2'b00, 32'hFFFFFF80, 4'b1000, 32'h0);
    vt[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 2, 1, 2'b00, 32'h00000080, 4'b1000, 32'h0);
    vt[3]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0, 2, 1, 2'b00, 32'hFFFF80FF, 4'b1100, 32'h0);
    vt[4]  = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h80FF0000, 0, 2, 1, 2'b00, 32'h000080FF, 4'b1100, 32'h0);
    vt[5]  = mk(0, 1, 3'b011, 32'h2, 32'h12345678, 32'hFFFFFFFF, 0, 2, 1, 2'b00, 32'h0, 4'b0100, 32'h78787878);
    vt[6]  = mk(0, 1, 3'b001, 32'h2, 32'h12345678, 32'hFFFFFFFF, 0, 2, 1, 2'b00, 32'h0, 4'b1100, 32'h56785678);
    vt[7]  = mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h11111111, 0, 1, 0, 2'b01, 32'h0, 4'b0000, 32'h0);
    vt[8]  = mk(0, 1, 3'b001, 32'h3, 32'hAAAA5555, 32'h0, 0, 1, 0, 2'b01, 32'h0, 4'b0000, 32'h0);
    vt[9]  = mk(1, 0, 3'b000, 32'h200, 32'h0, 32'h0BADF00D, 3, 5, 4, 2'b00, 32'h0BADF00D, 4'b1111, 32'h0);
    vt[10] = mk(1, 0, 3'b000, 32'h204, 32'h0, 32'h12121212, 255, 5, 4, 2'b10, 32'h0, 4'b1111, 32'h0);
    vt[11] = mk(0, 1, 3'b000, 32'h10, 32'hCAFEF00D, 32'h0, 1, 3, 2, 2'b00, 32'h0, 4'b1111, 32'hCAFEF00D);
    vt[12] = mk(1, 0, 3'b101, 32'h0, 32'h0, 32'h0, 0, 1, 0, 2'b01, 32'h0, 4'b0000, 32'h0);
    vt[13] = mk(0, 1, 3'b100, 32'h1, 32'h0, 32'h0, 0, 1, 0, 2'b01, 32'h0, 4'b0000, 32'h0);
    vt[14] = mk(1, 0, 3'b011, 32'h101, 32'h0, 32'h00007F00, 0, 2, 1, 2'b00, 32'h0000007F, 4'b0010, 32'h0);
    vt[15] = mk(1, 1, 3'b000, 32'h8, 32'h00000011, 32'hFFFFFFFF, 0, 2, 1, 2'b00, 32'h0, 4'b1111, 32'h00000011);

    // Reset state, with a pending request and mem_ready active
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset.mem_req_we", {30'h0, mem_req, mem_we}, 32'h0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.rsp_err", 32'(rsp_err), 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_be", 32'(mem_be), 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Non-access cycle: valid but neither load nor store
    @(negedge clk);
    req_valid = 1'b1; req_ld = 1'b0; req_st = 1'b0;
    #1;
    check("nonaccess.stall", 32'(stall), 32'h0);
    @(negedge clk);
    #1;
    check("nonaccess.mem_req", 32'(mem_req), 32'h0);
    req_valid = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_access(vt[i].ld, vt[i].st, vt[i].ctrl, vt[i].addr, vt[i].wd, vt[i].rd,
                vt[i].delay, 1'b1, o);
      compare($sformatf("vec%0d", i), o, vt[i].exp);
    end

    // Reset in the middle of a REQ wait abandons the access immediately
    @(negedge clk);
    req_valid = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_dm_ctrl = 3'b000;
    req_addr = 32'h300; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midreset.mem_req_before", 32'(mem_req), 32'h1);
    rstn = 1'b0;
    #1;
    check("midreset.mem_req", 32'(mem_req), 32'h0);
    check("midreset.stall", 32'(stall), 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b1;
    #1;
    check("midreset.idle_stall", 32'(stall), 32'h0);
    do_access(1'b1, 1'b0, 3'b000, 32'h304, 32'h0, 32'h5A5A1234, 0, 1'b0, o);
    compare("post_reset_lw", o, model(1'b0, 3'b000, 32'h304, 32'h0, 32'h5A5A1234, 0));

    // Randomized back-to-back accesses against the model
    for (int n = 0; n < 200; n++) begin
      logic ld, st;
      logic [2:0] ctrl;
      logic [31:0] addr, wd, rd;
      int unsigned dly, kind;
      kind = $urandom_range(0, 2);
      ld = (kind != 1);
      st = (kind != 0);
      ctrl = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = (ctrl == 3'b000) ? 2'b00 : {addr[1], 1'b0};
      wd = $urandom;
      rd = $urandom;
      dly = $urandom_range(0, TO + 1);
      do_access(ld, st, ctrl, addr, wd, rd, dly, 1'b1, o);
      e = model(st, ctrl, addr, wd, rd, dly);
      compare($sformatf("rnd%0d", n), o, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
